// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_pkg
// Description : Shared defaults and the drain state encoding used by the
//               vector register scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package vec_pkg;

    localparam int c_num_vec    = 32;
    localparam int c_addr_width = $clog2(c_num_vec);

    // Issue is only possible in RUN; DRAIN waits for all writes to retire.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } vec_state_t;

endpackage : vec_pkg
`default_nettype wire

// File: rtl/vec_busy_table.sv
`default_nettype none
// ============================================================================
// Module      : vec_busy_table
// Description : Per-register pending-write bit array with one set port, one
//               clear port, a global clear and three source-operand lookups.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_busy_table
    import vec_pkg::*;
#(
    parameter int NUM_VEC    = c_num_vec,
    parameter int ADDR_WIDTH = $clog2(NUM_VEC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_all,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr [3],
    output logic [2:0]            rd_bit,
    output logic [NUM_VEC-1:0]    busy
);

    logic [NUM_VEC-1:0] r_busy;
    logic [NUM_VEC-1:0] w_busy_nxt;

    // Next busy vector: global clear dominates, otherwise clear then set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (clear_all) begin
            w_busy_nxt = '0;
        end else begin
            if (clr_en) w_busy_nxt[clr_addr] = 1'b0;
            if (set_en) w_busy_nxt[set_addr] = 1'b1;
        end
    end

    // Busy bit storage, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_busy <= '0;
        else      r_busy <= w_busy_nxt;
    end

    // Lookups read only the registered bits: no writeback bypass.
    for (genvar g = 0; g < 3; g++) begin : g_rd
        assign rd_bit[g] = r_busy[rd_addr[g]];
    end

    assign busy = r_busy;

endmodule : vec_busy_table
`default_nettype wire

// File: rtl/vec_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : vec_scoreboard
// Description : Vector register scoreboard. Blocks issue on RAW/WAW hazards
//               and on a full in-flight write budget, tracks writebacks,
//               supports flush and a drain handshake, flags bad writebacks.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_scoreboard
    import vec_pkg::*;
#(
    parameter int NUM_VEC    = c_num_vec,
    parameter int ADDR_WIDTH = $clog2(NUM_VEC),
    parameter int MAX_OUT    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iss_valid,
    output logic                         iss_ready,
    input  logic                         iss_use_vs1,
    input  logic                         iss_use_vs2,
    input  logic                         iss_use_vs3,
    input  logic                         iss_wr_vd,
    input  logic [ADDR_WIDTH-1:0]        iss_vs1,
    input  logic [ADDR_WIDTH-1:0]        iss_vs2,
    input  logic [ADDR_WIDTH-1:0]        iss_vs3,
    input  logic [ADDR_WIDTH-1:0]        iss_vd,
    input  logic                         wb_valid,
    input  logic [ADDR_WIDTH-1:0]        wb_addr,
    input  logic                         flush,
    input  logic                         drain_req,
    output logic [NUM_VEC-1:0]           busy,
    output logic [$clog2(MAX_OUT+1)-1:0] out_cnt,
    output logic                         drain_done,
    output logic                         err
);

    localparam int CNT_W = $clog2(MAX_OUT+1);
    localparam logic [CNT_W-1:0] c_max_out = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    vec_state_t              r_state;
    vec_state_t              w_state_nxt;
    logic [CNT_W-1:0]        r_out_cnt;
    logic                    r_err;
    logic [NUM_VEC-1:0]      w_busy;
    logic [2:0]              w_src_busy;
    logic [ADDR_WIDTH-1:0]   w_rd_addr [3];
    logic                    w_hazard;
    logic                    w_issue_wr;
    logic                    w_wb_hit;
    logic                    w_wb_bad;
    logic                    w_drain_done;

    assign w_rd_addr[0] = iss_vs1;
    assign w_rd_addr[1] = iss_vs2;
    assign w_rd_addr[2] = iss_vs3;

    vec_busy_table #(
        .NUM_VEC    (NUM_VEC),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_busy_table (
        .clk       (clk),
        .rst       (rst),
        .clear_all (flush),
        .set_en    (w_issue_wr),
        .set_addr  (iss_vd),
        .clr_en    (w_wb_hit),
        .clr_addr  (wb_addr),
        .rd_addr   (w_rd_addr),
        .rd_bit    (w_src_busy),
        .busy      (w_busy)
    );

    // Destination (WAW) check reads the full vector directly; sources go
    // through the table's lookup ports.
    assign w_hazard = (iss_use_vs1 & w_src_busy[0])
                    | (iss_use_vs2 & w_src_busy[1])
                    | (iss_use_vs3 & w_src_busy[2])
                    | (iss_wr_vd   & w_busy[iss_vd]);

    assign iss_ready = (r_state == RUN) & ~w_hazard
                     & ~(iss_wr_vd & (r_out_cnt == c_max_out)) & ~flush;

    // Flush discards same-cycle issue and writeback, including their errors.
    assign w_issue_wr = iss_valid & iss_ready & iss_wr_vd;
    assign w_wb_hit   = wb_valid & ~flush &  w_busy[wb_addr];
    assign w_wb_bad   = wb_valid & ~flush & ~w_busy[wb_addr];

    // In-flight counter: simultaneous issue and retire cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_cnt <= '0;
        end else if (flush) begin
            r_out_cnt <= '0;
        end else begin
            case ({w_issue_wr, w_wb_hit})
                2'b10:   r_out_cnt <= r_out_cnt + c_one;
                2'b01:   r_out_cnt <= r_out_cnt - c_one;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    // Sticky error on a writeback to a register with no pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_err <= 1'b0;
        else      r_err <= r_err | w_wb_bad;
    end

    // Drain state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= RUN;
        else      r_state <= w_state_nxt;
    end

    // Drain next-state and completion pulse; the pulse marks DRAIN -> RUN.
    always_comb begin
        w_state_nxt  = r_state;
        w_drain_done = 1'b0;
        if (flush) begin
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (drain_req) w_state_nxt = DRAIN;
                end
                DRAIN: begin
                    if (r_out_cnt == '0) begin
                        w_state_nxt  = RUN;
                        w_drain_done = 1'b1;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    assign busy       = w_busy;
    assign out_cnt    = r_out_cnt;
    assign err        = r_err;
    assign drain_done = w_drain_done;

endmodule : vec_scoreboard
`default_nettype wire

// File: tb/tb_vec_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_scoreboard
// Description : Directed self-checking bench for vec_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid, iss_ready;
    logic        iss_use_vs1, iss_use_vs2, iss_use_vs3, iss_wr_vd;
    logic [4:0]  iss_vs1, iss_vs2, iss_vs3, iss_vd;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        flush, drain_req;
    logic [31:0] busy;
    logic [2:0]  out_cnt;
    logic        drain_done, err;

    int n_vec = 0;
    int n_mis = 0;

    vec_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_use_vs1 (iss_use_vs1),
        .iss_use_vs2 (iss_use_vs2),
        .iss_use_vs3 (iss_use_vs3),
        .iss_wr_vd   (iss_wr_vd),
        .iss_vs1     (iss_vs1),
        .iss_vs2     (iss_vs2),
        .iss_vs3     (iss_vs3),
        .iss_vd      (iss_vd),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .flush       (flush),
        .drain_req   (drain_req),
        .busy        (busy),
        .out_cnt     (out_cnt),
        .drain_done  (drain_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        iss_valid = 0; iss_use_vs1 = 0; iss_use_vs2 = 0; iss_use_vs3 = 0; iss_wr_vd = 0;
        iss_vs1 = 0; iss_vs2 = 0; iss_vs3 = 0; iss_vd = 0;
        wb_valid = 0; wb_addr = 0; flush = 0; drain_req = 0;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_wr(input logic [4:0] vd);
        idle();
        iss_valid = 1; iss_wr_vd = 1; iss_vd = vd;
    endtask

    task automatic wb(input logic [4:0] a);
        idle();
        wb_valid = 1; wb_addr = a;
    endtask

    initial begin
        idle();
        rst = 0;
        #2;
        chk("reset_busy",  busy, 32'h0);
        chk("reset_cnt",   {29'd0, out_cnt}, 32'd0);
        chk("reset_err",   {31'd0, err}, 32'd0);
        chk("reset_ddone", {31'd0, drain_done}, 32'd0);
        cyc();
        rst = 1;
        #1;
        chk("reset_ready", {31'd0, iss_ready}, 32'd1);

        // RAW hazard on v5 until its writeback retires
        issue_wr(5'd5); #1;
        chk("v5_ready", {31'd0, iss_ready}, 32'd1);
        cyc();
        chk("v5_busy", busy, 32'h0000_0020);
        chk("v5_cnt",  {29'd0, out_cnt}, 32'd1);
        idle(); iss_valid = 1; iss_use_vs1 = 1; iss_vs1 = 5'd5; #1;
        chk("raw_blocked", {31'd0, iss_ready}, 32'd0);
        cyc();
        chk("raw_still_blocked", {31'd0, iss_ready}, 32'd0);
        wb_valid = 1; wb_addr = 5'd5; #1;
        chk("raw_no_bypass", {31'd0, iss_ready}, 32'd0);
        cyc();
        wb_valid = 0; #1;
        chk("raw_released", {31'd0, iss_ready}, 32'd1);
        chk("raw_busy", busy, 32'h0);
        chk("raw_cnt", {29'd0, out_cnt}, 32'd0);
        cyc();

        // Fill the in-flight budget with v1..v4
        for (int i = 1; i <= 4; i++) begin
            issue_wr(5'(i)); #1;
            chk("fill_ready", {31'd0, iss_ready}, 32'd1);
            cyc();
        end
        chk("fill_busy", busy, 32'h0000_001E);
        chk("fill_cnt", {29'd0, out_cnt}, 32'd4);
        issue_wr(5'd10); #1;
        chk("full_wr_blocked", {31'd0, iss_ready}, 32'd0);
        idle(); iss_valid = 1; iss_use_vs1 = 1; iss_vs1 = 5'd10; #1;
        chk("full_nonwr_ready", {31'd0, iss_ready}, 32'd1);
        cyc();
        chk("full_nonwr_cnt", {29'd0, out_cnt}, 32'd4);

        // Retire v1, v2, then issue v7 while retiring v3
        wb(5'd1); cyc();
        wb(5'd2); cyc();
        chk("retire_cnt", {29'd0, out_cnt}, 32'd2);
        issue_wr(5'd7); wb_valid = 1; wb_addr = 5'd3; #1;
        chk("overlap_ready", {31'd0, iss_ready}, 32'd1);
        cyc();
        idle();
        chk("overlap_cnt", {29'd0, out_cnt}, 32'd2);
        chk("overlap_busy", busy, 32'h0000_0090);

        // Bad writeback to v9, error survives flush
        wb(5'd9); cyc(); idle();
        chk("badwb_err", {31'd0, err}, 32'd1);
        chk("badwb_cnt", {29'd0, out_cnt}, 32'd2);
        chk("badwb_busy", busy, 32'h0000_0090);
        issue_wr(5'd1); flush = 1; #1;
        chk("flush_ready", {31'd0, iss_ready}, 32'd0);
        cyc(); idle();
        chk("flush_busy", busy, 32'h0);
        chk("flush_cnt", {29'd0, out_cnt}, 32'd0);
        chk("flush_err_held", {31'd0, err}, 32'd1);

        // Drain with two writes outstanding
        issue_wr(5'd1); cyc();
        issue_wr(5'd2); cyc();
        idle(); drain_req = 1; cyc();
        idle(); iss_valid = 1; iss_use_vs1 = 1; iss_vs1 = 5'd20; #1;
        chk("drain_ready", {31'd0, iss_ready}, 32'd0);
        chk("drain_no_done", {31'd0, drain_done}, 32'd0);
        wb(5'd1); cyc();
        chk("drain_cnt1", {29'd0, out_cnt}, 32'd1);
        chk("drain_done_early", {31'd0, drain_done}, 32'd0);
        wb(5'd2); cyc(); idle(); #1;
        chk("drain_done_pulse", {31'd0, drain_done}, 32'd1);
        chk("drain_last_ready", {31'd0, iss_ready}, 32'd0);
        cyc();
        chk("drain_done_end", {31'd0, drain_done}, 32'd0);
        chk("drain_run_ready", {31'd0, iss_ready}, 32'd1);

        // Drain with nothing outstanding pulses on the following cycle
        drain_req = 1; #1;
        chk("drain0_not_yet", {31'd0, drain_done}, 32'd0);
        cyc(); idle(); #1;
        chk("drain0_pulse", {31'd0, drain_done}, 32'd1);
        cyc();
        chk("drain0_end", {31'd0, drain_done}, 32'd0);
        chk("drain0_ready", {31'd0, iss_ready}, 32'd1);

        // Flush with v4..v7 busy and full budget
        for (int i = 4; i <= 7; i++) begin
            issue_wr(5'(i)); cyc();
        end
        idle();
        chk("pre_flush_busy", busy, 32'h0000_00F0);
        chk("pre_flush_cnt", {29'd0, out_cnt}, 32'd4);
        flush = 1; cyc(); idle();
        chk("flush2_busy", busy, 32'h0);
        chk("flush2_cnt", {29'd0, out_cnt}, 32'd0);

        // Reset in the middle of a drain
        issue_wr(5'd3); cyc();
        idle(); drain_req = 1; cyc(); idle(); #1;
        chk("middrain_ready", {31'd0, iss_ready}, 32'd0);
        #2;
        rst = 0; #1;
        chk("rst_busy", busy, 32'h0);
        chk("rst_cnt", {29'd0, out_cnt}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ddone", {31'd0, drain_done}, 32'd0);
        cyc();
        rst = 1; #1;
        chk("rst_ready", {31'd0, iss_ready}, 32'd1);
        cyc();
        chk("rst_run_ready", {31'd0, iss_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule : tb_vec_scoreboard
`default_nettype wire

// File: doc/vec_scoreboard.md
VEC_SCOREBOARD -- requirements
Module: vec_scoreboard

Interface
REQ-001 SHALL have parameter NUM_VEC, default 32, number of vector registers tracked.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(NUM_VEC), register index width.
REQ-003 SHALL have parameter MAX_OUT, default 4, maximum in-flight vector writes.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port iss_valid  input  1  decoded instruction offered for issue.
REQ-007 SHALL have port iss_ready  output  1  instruction may issue this cycle.
REQ-008 SHALL have ports iss_use_vs1, iss_use_vs2, iss_use_vs3, iss_wr_vd  input  1 each  operand-use flags.
REQ-009 SHALL have ports iss_vs1, iss_vs2, iss_vs3, iss_vd  input  ADDR_WIDTH each  register indices.
REQ-010 SHALL have ports wb_valid  input  1 and wb_addr  input  ADDR_WIDTH  writeback completion.
REQ-011 SHALL have ports flush  input  1 and drain_req  input  1  pipeline control.
REQ-012 SHALL have ports busy  output  NUM_VEC  per-register pending-write bits, and out_cnt  output  $clog2(MAX_OUT+1)  in-flight count.
REQ-013 SHALL have ports drain_done  output  1  one-cycle pulse, and err  output  1  sticky protocol error.

Function
REQ-014 SHALL compute hazard = (use_vs1 & busy[vs1]) | (use_vs2 & busy[vs2]) | (use_vs3 & busy[vs3]) | (wr_vd & busy[vd]) from registered busy only; no same-cycle writeback bypass.
REQ-015 SHALL drive iss_ready = state RUN & ~hazard & ~(iss_wr_vd & out_cnt==MAX_OUT) & ~flush, combinationally.
REQ-016 SHALL accept an issue when iss_valid & iss_ready; accepted issue with iss_wr_vd sets busy[iss_vd] and increments out_cnt at the next edge.
REQ-017 SHALL on wb_valid clear busy[wb_addr] and decrement out_cnt at the next edge.
REQ-018 SHALL leave out_cnt unchanged when a counted issue and a writeback occur in the same cycle; busy set and clear of different registers both take effect.
REQ-019 SHALL, if wb_valid targets a non-busy register, set err, leave busy and out_cnt unchanged (no underflow).
REQ-020 SHALL hold err at 1 until reset; flush does not clear err.
REQ-021 SHALL on flush clear all busy bits and out_cnt to 0 next edge, ignore same-cycle issue and writeback, and return state to RUN.
REQ-022 SHALL implement states RUN and DRAIN; RUN -> DRAIN when drain_req=1; DRAIN -> RUN when out_cnt==0 (including the cycle of entry), pulsing drain_done for exactly one cycle on that transition.
REQ-023 SHALL keep accepting writebacks while in DRAIN; iss_ready is 0 throughout DRAIN.
REQ-024 SHALL ignore drain_req while already in DRAIN.

Reset
REQ-025 SHALL on rst=0 asynchronously force busy=0, out_cnt=0, err=0, drain_done=0, state=RUN; iss_ready therefore 1 when rst deasserts.
REQ-026 SHALL treat reset mid-operation as discarding all pending writes with no err.

Structure
REQ-027 SHALL place NUM_VEC, ADDR_WIDTH defaults and the state enum (RUN, DRAIN) in shared package vec_pkg.
REQ-028 SHALL implement the busy bit array with set/clear ports and three-read hazard lookup as sub-module vec_busy_table.

Verification
REQ-029 SHALL cover: issue wr_vd=1 vd=5 -> busy[5]=1, out_cnt=1; issue use_vs1=1 vs1=5 -> iss_ready=0 until wb_addr=5, then ready next cycle.
REQ-030 SHALL cover: four writes to v1..v4 with MAX_OUT=4 -> iss_ready=0 for fifth write, 1 for a non-writing instruction with no hazard.
REQ-031 SHALL cover: same-cycle issue vd=7 and wb v3 with out_cnt=2 -> out_cnt stays 2, busy[7]=1, busy[3]=0.
REQ-032 SHALL cover: wb_addr=9 with busy[9]=0 -> err=1, out_cnt unchanged, err held after flush.
REQ-033 SHALL cover: drain_req with out_cnt=2 -> iss_ready=0, drain_done pulses one cycle after second wb, state RUN; drain_req with out_cnt=0 -> pulse next cycle.
REQ-034 SHALL cover: flush with busy=0x0000_00F0, out_cnt=4 -> busy=0, out_cnt=0; rst=0 mid-drain -> RUN, all outputs reset.
